// File: rtl/niu_pc_unit_if.sv
// Command/status bundle between the Niu32 control FSM (master) and the PC unit (slave).
// The FSM drives one-cycle command strobes and the unit reports registered PC/RAS state.
interface niu_pc_unit_if #(
    parameter int WORD_SIZE = 32
);
    logic                 stall;
    logic                 ld_pc;
    logic [WORD_SIZE-1:0] pc_in;
    logic                 inc_pc;
    logic                 br_pc;
    logic [WORD_SIZE-1:0] br_off;
    logic                 call;
    logic                 ret;
    logic                 exc;
    logic                 eret;
    logic [WORD_SIZE-1:0] pc_out;
    logic [WORD_SIZE-1:0] epc;
    logic [1:0]           cause;
    logic                 ras_empty;
    logic                 ras_full;
    logic                 ras_ovf;

    modport master (
        output stall, ld_pc, pc_in, inc_pc, br_pc, br_off, call, ret, exc, eret,
        input  pc_out, epc, cause, ras_empty, ras_full, ras_ovf
    );

    modport slave (
        input  stall, ld_pc, pc_in, inc_pc, br_pc, br_off, call, ret, exc, eret,
        output pc_out, epc, cause, ras_empty, ras_full, ras_ovf
    );
endinterface

// File: rtl/niu_pc_unit.sv
// Niu32 program-counter unit: registered PC, exception PC/cause and a circular
// return-address stack, updated by prioritised one-cycle commands.
module niu_pc_unit #(
    parameter int                   WORD_SIZE   = 32,
    parameter int                   INSTR_SIZE  = 4,
    parameter logic [WORD_SIZE-1:0] PC_STARTLOC = 32'h0,
    parameter logic [WORD_SIZE-1:0] EXC_VECTOR  = 32'h00000100,
    parameter int                   RAS_DEPTH   = 8,
    parameter bit                   ALIGN_CHECK = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    niu_pc_unit_if.slave    i_pcu
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [WORD_SIZE-1:0] INC_STEP   = WORD_SIZE'(INSTR_SIZE);
    localparam logic [WORD_SIZE-1:0] ALIGN_MASK = WORD_SIZE'(INSTR_SIZE - 1);
    localparam logic [CNT_W-1:0]     CNT_FULL   = CNT_W'(RAS_DEPTH);
    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_EXT   = 2'd1;
    localparam logic [1:0] CAUSE_ALIGN = 2'd2;
    localparam logic [1:0] CAUSE_UNDER = 2'd3;

    logic [WORD_SIZE-1:0] r_pc;
    logic [WORD_SIZE-1:0] r_epc;
    logic [1:0]           r_cause;
    logic [CNT_W-1:0]     r_cnt;
    logic [PTR_W-1:0]     r_ptr;
    logic                 r_ovf;
    logic [WORD_SIZE-1:0] r_ras [RAS_DEPTH];

    logic [WORD_SIZE-1:0] w_seq_pc;
    logic [WORD_SIZE-1:0] w_br_tgt;
    logic [PTR_W-1:0]     w_top_idx;
    logic [WORD_SIZE-1:0] w_top;
    logic [WORD_SIZE-1:0] w_pc_nxt;
    logic [WORD_SIZE-1:0] w_epc_nxt;
    logic [1:0]           w_cause_nxt;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_trap;
    logic [1:0]           w_trap_cause;

    // r_ptr is the next free slot, so the top of stack sits one below it.
    assign w_seq_pc  = r_pc + INC_STEP;
    assign w_br_tgt  = r_pc + i_pcu.br_off;
    assign w_top_idx = r_ptr - PTR_W'(1);
    assign w_top     = r_ras[w_top_idx];

    function automatic logic f_misaligned(input logic [WORD_SIZE-1:0] target);
        return ALIGN_CHECK && ((target & ALIGN_MASK) != '0);
    endfunction

    always_comb begin
        w_pc_nxt     = r_pc;
        w_epc_nxt    = r_epc;
        w_cause_nxt  = r_cause;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_trap       = 1'b0;
        w_trap_cause = CAUSE_NONE;
        if (i_pcu.exc) begin
            w_trap       = 1'b1;
            w_trap_cause = CAUSE_EXT;
        end else if (!i_pcu.stall) begin
            if (i_pcu.eret) begin
                w_pc_nxt    = r_epc;
                w_cause_nxt = CAUSE_NONE;
            end else if (i_pcu.ret) begin
                if (r_cnt == '0) begin
                    w_trap       = 1'b1;
                    w_trap_cause = CAUSE_UNDER;
                end else if (f_misaligned(w_top)) begin
                    w_trap       = 1'b1;
                    w_trap_cause = CAUSE_ALIGN;
                end else begin
                    w_pc_nxt = w_top;
                    w_pop    = 1'b1;
                end
            end else if (i_pcu.ld_pc) begin
                if (f_misaligned(i_pcu.pc_in)) begin
                    w_trap       = 1'b1;
                    w_trap_cause = CAUSE_ALIGN;
                end else begin
                    w_pc_nxt = i_pcu.pc_in;
                    w_push   = i_pcu.call;
                end
            end else if (i_pcu.br_pc) begin
                if (f_misaligned(w_br_tgt)) begin
                    w_trap       = 1'b1;
                    w_trap_cause = CAUSE_ALIGN;
                end else begin
                    w_pc_nxt = w_br_tgt;
                    w_push   = i_pcu.call;
                end
            end else if (i_pcu.inc_pc) begin
                w_pc_nxt = w_seq_pc;
            end
        end
        if (w_trap) begin
            w_pc_nxt    = EXC_VECTOR;
            w_epc_nxt   = r_pc;
            w_cause_nxt = w_trap_cause;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= PC_STARTLOC;
            r_epc   <= '0;
            r_cause <= CAUSE_NONE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_epc   <= w_epc_nxt;
            r_cause <= w_cause_nxt;
            // A push while full overwrites the oldest entry, which is the slot at r_ptr.
            if (w_push) begin
                r_ptr <= r_ptr + PTR_W'(1);
                if (r_cnt == CNT_FULL) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (w_pop) begin
                r_ptr <= w_top_idx;
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[r_ptr] <= w_seq_pc;
        end
    end

    assign i_pcu.pc_out    = r_pc;
    assign i_pcu.epc       = r_epc;
    assign i_pcu.cause     = r_cause;
    assign i_pcu.ras_empty = (r_cnt == '0);
    assign i_pcu.ras_full  = (r_cnt == CNT_FULL);
    assign i_pcu.ras_ovf   = r_ovf;
endmodule

// File: tb/tb_niu_pc_unit.sv
// Directed and random checks of niu_pc_unit: sequencing, branches, call/return
// stack, alignment traps, priorities, stall/exception and asynchronous reset.
module tb_niu_pc_unit;
    localparam logic [7:0] C_IDLE  = 8'h00;
    localparam logic [7:0] C_STALL = 8'h01;
    localparam logic [7:0] C_LD    = 8'h02;
    localparam logic [7:0] C_INC   = 8'h04;
    localparam logic [7:0] C_BR    = 8'h08;
    localparam logic [7:0] C_CALL  = 8'h10;
    localparam logic [7:0] C_RET   = 8'h20;
    localparam logic [7:0] C_EXC   = 8'h40;
    localparam logic [7:0] C_ERET  = 8'h80;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    // Expected state carried between steps: epc, cause, RAS occupancy, overflow flag.
    logic [31:0] m_epc;
    logic [1:0]  m_cause;
    int          m_cnt;
    logic        m_ovf;
    logic [68:0] exp_q[$];

    niu_pc_unit_if #(.WORD_SIZE(32)) pcu ();

    niu_pc_unit #(
        .WORD_SIZE  (32),
        .INSTR_SIZE (4),
        .PC_STARTLOC(32'h0),
        .EXC_VECTOR (32'h00000100),
        .RAS_DEPTH  (8),
        .ALIGN_CHECK(1'b1)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .i_pcu(pcu)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] cmd, input logic [31:0] pin, input logic [31:0] off);
        pcu.stall  = cmd[0];
        pcu.ld_pc  = cmd[1];
        pcu.inc_pc = cmd[2];
        pcu.br_pc  = cmd[3];
        pcu.call   = cmd[4];
        pcu.ret    = cmd[5];
        pcu.exc    = cmd[6];
        pcu.eret   = cmd[7];
        pcu.pc_in  = pin;
        pcu.br_off = off;
    endtask

    task automatic push_exp(input logic [31:0] exp_pc);
        logic e_empty;
        logic e_full;
        e_empty = (m_cnt == 0);
        e_full  = (m_cnt == 8);
        exp_q.push_back({exp_pc, m_epc, m_cause, e_empty, e_full, m_ovf});
    endtask

    task automatic compare_out(input string tag);
        logic [68:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s.queue: got empty expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".pc"},    pcu.pc_out,           e[68:37]);
            check({tag, ".epc"},   pcu.epc,              e[36:5]);
            check({tag, ".cause"}, 32'(pcu.cause),       32'(e[4:3]));
            check({tag, ".flags"}, 32'({pcu.ras_empty, pcu.ras_full, pcu.ras_ovf}), 32'(e[2:0]));
        end
    endtask

    task automatic step(input string tag, input logic [7:0] cmd, input logic [31:0] pin,
                        input logic [31:0] off, input logic [31:0] exp_pc);
        @(negedge clk);
        drive(cmd, pin, off);
        push_exp(exp_pc);
        @(posedge clk);
        #1;
        drive(C_IDLE, 32'h0, 32'h0);
        compare_out(tag);
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] off;
        logic [7:0]  cmd;
        n_checks = 0;
        n_errors = 0;
        m_epc    = 32'h0;
        m_cause  = 2'd0;
        m_cnt    = 0;
        m_ovf    = 1'b0;
        reset    = 1'b1;
        drive(C_IDLE, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        push_exp(32'h0);
        compare_out("reset");
        @(negedge clk);
        reset = 1'b0;

        step("start", C_IDLE, 0, 0, 32'h0);
        step("inc1", C_INC, 0, 0, 32'h4);
        step("inc2", C_INC, 0, 0, 32'h8);
        step("inc3", C_INC, 0, 0, 32'hC);

        step("ld40", C_LD, 32'h40, 0, 32'h40);
        step("br_neg", C_BR, 0, 32'hFFFF_FFF8, 32'h38);
        step("ld_top", C_LD, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC);
        step("inc_wrap", C_INC, 0, 0, 32'h0);

        step("ld10", C_LD, 32'h10, 0, 32'h10);
        m_cnt = 1;
        step("call200", C_LD | C_CALL, 32'h200, 0, 32'h200);
        m_cnt = 0;
        step("ret14", C_RET, 0, 0, 32'h14);

        for (int i = 0; i < 9; i++) begin
            if (m_cnt < 8) m_cnt++;
            if (i == 8) m_ovf = 1'b1;
            step($sformatf("call%0d", i), C_LD | C_CALL, 32'h1000 + 32'(i) * 32'h100, 0,
                 32'h1000 + 32'(i) * 32'h100);
        end
        for (int k = 8; k >= 1; k--) begin
            m_cnt--;
            step($sformatf("ret%0d", k), C_RET, 0, 0, 32'h1004 + 32'(k - 1) * 32'h100);
        end
        m_epc   = 32'h1004;
        m_cause = 2'd3;
        step("ret_under", C_RET, 0, 0, 32'h100);

        step("ld300", C_LD, 32'h300, 0, 32'h300);
        m_epc   = 32'h300;
        m_cause = 2'd2;
        step("ld_mis", C_LD | C_CALL, 32'h202, 0, 32'h100);
        m_cause = 2'd0;
        step("eret", C_ERET, 0, 0, 32'h300);

        step("prio_ld", C_LD | C_BR | C_INC, 32'h400, 32'h40, 32'h400);
        step("prio_br", C_BR | C_INC, 0, 32'h10, 32'h410);
        m_epc   = 32'h410;
        m_cause = 2'd2;
        step("br_mis", C_BR, 0, 32'h6, 32'h100);
        m_cause = 2'd0;
        step("prio_eret", C_ERET | C_RET | C_LD, 32'h900, 0, 32'h410);
        step("call_alone", C_CALL | C_INC, 0, 0, 32'h414);
        m_epc   = 32'h414;
        m_cause = 2'd3;
        step("ret_empty", C_RET | C_CALL | C_LD, 32'h700, 0, 32'h100);
        step("ld80", C_LD, 32'h80, 0, 32'h80);

        m_epc   = 32'h80;
        m_cause = 2'd1;
        step("stall_exc", C_STALL | C_INC | C_EXC, 0, 0, 32'h100);
        step("stall_inc", C_STALL | C_INC, 0, 0, 32'h100);
        step("stall_ld", C_STALL | C_LD, 32'h500, 0, 32'h100);

        step("ld8", C_LD, 32'h8, 0, 32'h8);
        step("br_wrap", C_BR, 0, 32'hFFFF_FFF0, 32'hFFFF_FFF8);
        m_cnt = 1;
        step("call600", C_LD | C_CALL, 32'h600, 0, 32'h600);
        m_cnt = 0;
        step("ret_call", C_RET | C_CALL | C_LD, 32'h800, 0, 32'hFFFF_FFFC);

        pc = 32'hFFFF_FFFC;
        for (int n = 0; n < 40; n++) begin
            int k;
            cmd = ($urandom_range(0, 3) == 0) ? C_STALL : C_IDLE;
            k   = int'($urandom_range(0, 64));
            off = 32'((k - 32) * 4);
            case ($urandom_range(0, 2))
                0:       cmd = cmd | C_INC;
                1:       cmd = cmd | C_BR;
                default: cmd = cmd;
            endcase
            if (!cmd[0]) begin
                if (cmd[2]) pc = pc + 32'd4;
                else if (cmd[3]) pc = pc + off;
            end
            step($sformatf("rnd%0d", n), cmd, 0, off, pc);
        end

        m_cnt = 1;
        step("call700", C_LD | C_CALL, 32'h700, 0, 32'h700);
        @(negedge clk);
        drive(C_STALL | C_LD | C_CALL, 32'h800, 0);
        #2;
        reset   = 1'b1;
        m_epc   = 32'h0;
        m_cause = 2'd0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        #1;
        push_exp(32'h0);
        compare_out("rst_async");
        @(posedge clk);
        #1;
        push_exp(32'h0);
        compare_out("rst_hold");
        drive(C_IDLE, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step("post_rst", C_IDLE, 0, 0, 32'h0);
        step("post_inc", C_INC, 0, 0, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
